// File: rtl/decoder_scan_ctrl.sv
// Purpose: sequencer that scans the enabled positions of a 3-8 decoder, holding each position for DIV cycles.
// Latency: one cycle from sampled iRun/iMask to registered oData/oEna; all outputs are registered.
// Backpressure: none; the scan is free-running, and iRun=0 or an empty iMask parks the decoder disabled.
module decoder_scan_ctrl #(
    parameter int DIV = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iRun,
    input  logic [7:0] iMask,
    output logic [2:0] oData,
    output logic [1:0] oEna,
    output logic       oStep,
    output logic       oActive
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DIV - 1);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SCAN = 1'b1;

    localparam logic [1:0] ENA_ON  = 2'b10;
    localparam logic [1:0] ENA_OFF = 2'b01;

    logic          state;
    logic [CW-1:0] dwellCnt;
    logic [2:0]    lowestIdx;
    logic [2:0]    nextIdx;
    logic          runOk;

    // A scan can only start or continue while it is requested and has something to drive
    assign runOk = iRun && (iMask != 8'd0);

    // Lowest set bit of the mask: the first position of a fresh scan
    always_comb begin
        lowestIdx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (iMask[i]) begin
                lowestIdx = 3'(i);
            end
        end
    end

    // Next enabled position after the current one, wrapping; offset 8 lands back on the current index
    always_comb begin
        nextIdx = oData;
        for (int k = 8; k >= 1; k--) begin
            if (iMask[oData + 3'(k)]) begin
                nextIdx = oData + 3'(k);
            end
        end
    end

    // Scan state machine, dwell counter and registered decoder drive
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= STATE_IDLE;
            dwellCnt <= '0;
            oData    <= 3'd0;
            oEna     <= ENA_OFF;
            oStep    <= 1'b0;
            oActive  <= 1'b0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    oStep <= 1'b0;
                    if (runOk) begin
                        state    <= STATE_SCAN;
                        dwellCnt <= '0;
                        oData    <= lowestIdx;
                        oEna     <= ENA_ON;
                        oActive  <= 1'b1;
                    end
                end
                STATE_SCAN: begin
                    if (!runOk) begin
                        // Exit takes priority over a coinciding advance, so no step pulse
                        state    <= STATE_IDLE;
                        dwellCnt <= '0;
                        oData    <= 3'd0;
                        oEna     <= ENA_OFF;
                        oStep    <= 1'b0;
                        oActive  <= 1'b0;
                    end else if (dwellCnt == DWELL_LAST) begin
                        dwellCnt <= '0;
                        oData    <= nextIdx;
                        oStep    <= 1'b1;
                    end else begin
                        dwellCnt <= dwellCnt + 1'b1;
                        oStep    <= 1'b0;
                    end
                end
                default: begin
                    state    <= STATE_IDLE;
                    dwellCnt <= '0;
                    oData    <= 3'd0;
                    oEna     <= ENA_OFF;
                    oStep    <= 1'b0;
                    oActive  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: three instances (DIV = 4, 2, 1) checked every cycle against a scoreboard.
// Expected outputs are queued when stimulus is driven and compared after the following clock edge.
// Direct sequence checks derived from the scan order complement the per-cycle scoreboard.
module tb_decoder_scan_ctrl;

    typedef struct {
        logic [2:0] d;
        logic [1:0] e;
        logic       s;
        logic       a;
    } exp_t;

    logic       iClk;
    logic       iRst;
    logic       run      [3];
    logic [7:0] mask     [3];
    logic [2:0] outData  [3];
    logic [1:0] outEna   [3];
    logic       outStep  [3];
    logic       outActive[3];

    int errCount;
    int checkCount;

    exp_t expQ [3][$];
    bit   mScan[3];
    int   mPos [3];
    int   mCnt [3];

    decoder_scan_ctrl #(.DIV(4)) u0 (
        .iClk(iClk), .iRst(iRst), .iRun(run[0]), .iMask(mask[0]),
        .oData(outData[0]), .oEna(outEna[0]), .oStep(outStep[0]), .oActive(outActive[0])
    );
    decoder_scan_ctrl #(.DIV(2)) u1 (
        .iClk(iClk), .iRst(iRst), .iRun(run[1]), .iMask(mask[1]),
        .oData(outData[1]), .oEna(outEna[1]), .oStep(outStep[1]), .oActive(outActive[1])
    );
    decoder_scan_ctrl #(.DIV(1)) u2 (
        .iClk(iClk), .iRst(iRst), .iRun(run[2]), .iMask(mask[2]),
        .oData(outData[2]), .oEna(outEna[2]), .oStep(outStep[2]), .oActive(outActive[2])
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input int got, input int want);
        checkCount++;
        if (got !== want) begin
            errCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic int divOf(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    // Reference behaviour for one instance given the inputs about to be sampled
    task automatic modelStep(input int i);
        exp_t e;
        bit   step;
        step = 1'b0;
        if (iRst) begin
            mScan[i] = 1'b0;
            mPos[i]  = 0;
            mCnt[i]  = 0;
        end else if (!mScan[i]) begin
            if (run[i] && mask[i] != 8'd0) begin
                mScan[i] = 1'b1;
                mCnt[i]  = 0;
                for (int b = 7; b >= 0; b--) if (mask[i][b]) mPos[i] = b;
            end
        end else if (!run[i] || mask[i] == 8'd0) begin
            mScan[i] = 1'b0;
            mPos[i]  = 0;
            mCnt[i]  = 0;
        end else if (mCnt[i] == divOf(i) - 1) begin
            int p;
            p = mPos[i];
            for (int k = 8; k >= 1; k--) if (mask[i][(p + k) % 8]) mPos[i] = (p + k) % 8;
            mCnt[i] = 0;
            step    = 1'b1;
        end else begin
            mCnt[i]++;
        end
        e.d = 3'(mPos[i]);
        e.e = mScan[i] ? 2'b10 : 2'b01;
        e.s = step;
        e.a = mScan[i];
        expQ[i].push_back(e);
    endtask

    // One clock: queue expectations from the driven inputs, then compare after the edge
    task automatic stepCycle();
        exp_t e;
        for (int i = 0; i < 3; i++) modelStep(i);
        @(posedge iClk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = expQ[i].pop_front();
            checkVal($sformatf("u%0d.oData", i),   int'(outData[i]),   int'(e.d));
            checkVal($sformatf("u%0d.oEna", i),    int'(outEna[i]),    int'(e.e));
            checkVal($sformatf("u%0d.oStep", i),   int'(outStep[i]),   int'(e.s));
            checkVal($sformatf("u%0d.oActive", i), int'(outActive[i]), int'(e.a));
        end
    endtask

    logic [2:0] sparseSeq [3];

    initial begin
        errCount   = 0;
        checkCount = 0;
        sparseSeq  = '{3'd0, 3'd2, 3'd7};
        iRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run[i]  = 1'b0;
            mask[i] = 8'd0;
            mScan[i] = 1'b0;
            mPos[i]  = 0;
            mCnt[i]  = 0;
        end

        // Reset and idle
        repeat (2) stepCycle();
        iRst = 1'b0;
        for (int i = 0; i < 3; i++) mask[i] = 8'hFF;
        repeat (4) stepCycle();
        checkVal("idleEna", int'(outEna[0]), 1);
        checkVal("idleData", int'(outData[0]), 0);

        // Full scan, DIV=4
        run[0] = 1'b1;
        stepCycle();
        for (int t = 0; t < 36; t++) begin
            checkVal("fullData", int'(outData[0]), (t / 4) % 8);
            checkVal("fullStep", int'(outStep[0]), (t > 0 && t % 4 == 0) ? 1 : 0);
            checkVal("fullEna", int'(outEna[0]), 2);
            stepCycle();
        end
        run[0] = 1'b0;
        stepCycle();
        checkVal("fullStopEna", int'(outEna[0]), 1);

        // Sparse mask, DIV=2, then mid-scan mask change
        mask[1] = 8'b1000_0101;
        run[1]  = 1'b1;
        stepCycle();
        for (int t = 0; t < 8; t++) begin
            checkVal("sparseData", int'(outData[1]), int'(sparseSeq[(t / 2) % 3]));
            checkVal("sparseStep", int'(outStep[1]), (t > 0 && t % 2 == 0) ? 1 : 0);
            stepCycle();
        end
        checkVal("sparseAt2", int'(outData[1]), 2);
        mask[1] = 8'b0000_0100;
        stepCycle();
        checkVal("sparseHold", int'(outData[1]), 2);
        checkVal("sparseHoldStep", int'(outStep[1]), 0);
        stepCycle();
        checkVal("singleData", int'(outData[1]), 2);
        checkVal("singleStep", int'(outStep[1]), 1);
        repeat (3) stepCycle();
        run[1] = 1'b0;
        stepCycle();

        // DIV=1 boundary
        mask[2] = 8'b0001_0001;
        run[2]  = 1'b1;
        stepCycle();
        for (int t = 0; t < 6; t++) begin
            checkVal("div1Data", int'(outData[2]), (t % 2 == 1) ? 4 : 0);
            checkVal("div1Step", int'(outStep[2]), (t > 0) ? 1 : 0);
            stepCycle();
        end
        mask[2] = 8'd0;
        stepCycle();
        checkVal("div1ExitEna", int'(outEna[2]), 1);
        checkVal("div1ExitAct", int'(outActive[2]), 0);
        checkVal("div1ExitStep", int'(outStep[2]), 0);
        // iRun held with empty mask stays idle, then starts on first nonzero mask
        repeat (3) stepCycle();
        checkVal("emptyIdle", int'(outActive[2]), 0);
        mask[2] = 8'h04;
        stepCycle();
        checkVal("lateStartAct", int'(outActive[2]), 1);
        checkVal("lateStartData", int'(outData[2]), 2);
        run[2] = 1'b0;
        stepCycle();

        // Stop mid-dwell on position 3, restart, reset during scan
        mask[0] = 8'hFF;
        run[0]  = 1'b1;
        stepCycle();
        repeat (14) stepCycle();
        checkVal("midPos", int'(outData[0]), 3);
        run[0] = 1'b0;
        stepCycle();
        checkVal("stopData", int'(outData[0]), 0);
        checkVal("stopEna", int'(outEna[0]), 1);
        mask[0] = 8'h08;
        run[0]  = 1'b1;
        stepCycle();
        checkVal("restartData", int'(outData[0]), 3);
        repeat (2) stepCycle();
        iRst = 1'b1;
        stepCycle();
        checkVal("rstData", int'(outData[0]), 0);
        checkVal("rstEna", int'(outEna[0]), 1);
        checkVal("rstAct", int'(outActive[0]), 0);
        iRst = 1'b0;
        stepCycle();
        checkVal("postRstData", int'(outData[0]), 3);
        run[0] = 1'b0;
        repeat (2) stepCycle();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
